// File: rtl/bus_uart_tx_pkg.sv
// Shared constants for the bus-attached UART transmitter: register offsets,
// STATUS/CTRL bit positions, FSM encodings and baud-divider helpers.
package bus_uart_tx_pkg;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_CTRL   = 4'h8;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_COUNT = 8;

    localparam int CT_ENABLE  = 0;
    localparam int CT_FLUSH   = 1;
    localparam int CT_CLR_OVF = 2;
    localparam int CT_IRQ_EN  = 3;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_ACK  = 2'd1,
        BUS_REL  = 2'd2
    } bus_state_t;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_START = 2'd1,
        SER_DATA  = 2'd2,
        SER_STOP  = 2'd3
    } ser_state_t;

    // Rounded clock cycles per bit.
    function automatic int baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/bus_uart_tx_fifo.sv
// Synchronous FIFO for transmit bytes: first-word-fall-through read port,
// registered full/empty/count, single-cycle flush.
module bus_uart_tx_fifo
    import bus_uart_tx_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic [AW:0]   count_next;

    // A push into a full FIFO is only taken when a pop frees a slot the same cycle.
    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        count_next = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= count_next[AW];
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the shared system bus: bus slave FSM,
// DATA/STATUS/CTRL registers, transmit FIFO and baud-timed serializer.
module bus_uart_tx
    import bus_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h7000_0000,
    parameter int          CLK_FREQ  = 50_000_000,
    parameter int          BAUD      = 115200,
    parameter int          FIFO_AW   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_bus,
    inout  wire  [31:0] data_bus,
    input  logic        rd_bus,
    input  logic        wr_bus,
    input  logic [3:0]  data_mask_bus,
    inout  wire         fc_bus,
    output logic        tx,
    output logic        irq
);

    localparam int          DIV      = baud_div(CLK_FREQ, BAUD);
    localparam int          CW       = cnt_width(DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    bus_state_t bus_state;
    bus_state_t bus_state_next;
    ser_state_t ser_state;
    ser_state_t ser_state_next;

    logic              sel;
    logic              wr_ack;
    logic              rd_ack;
    logic [3:0]        offset;
    logic              data_push;
    logic              ctrl_wr;
    logic              flush;
    logic              clr_ovf;
    logic [31:0]       status_val;
    logic [31:0]       ctrl_val;
    logic [31:0]       reg_val;
    logic [31:0]       rd_data;

    logic              enable;
    logic              irq_en;
    logic              overflow;

    logic [7:0]        fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_AW:0]  fifo_count;
    logic              ser_pop;
    logic              start_ok;
    logic              busy;

    logic [CW-1:0]     baud_cnt;
    logic              baud_done;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;

    // Bus handshake: the master raises rd_bus or wr_bus with a stable address
    // (and write data) and holds it until it sees fc_bus=1. fc_bus pulses for
    // exactly one cycle (ACK); read data is valid only in that cycle and write
    // side effects take effect at its closing edge. No new access is accepted
    // until both strobes have dropped (REL), so a held strobe is acked once.
    assign sel    = (addr_bus[31:4] == BASE_ADDR[31:4]) && (rd_bus || wr_bus);
    assign offset = addr_bus[3:0];
    assign wr_ack = (bus_state == BUS_ACK) && wr_bus;
    assign rd_ack = (bus_state == BUS_ACK) && rd_bus && !wr_bus;

    always_comb begin
        bus_state_next = bus_state;
        case (bus_state)
            BUS_IDLE: if (sel) bus_state_next = BUS_ACK;
            BUS_ACK:  bus_state_next = BUS_REL;
            BUS_REL:  if (!rd_bus && !wr_bus) bus_state_next = BUS_IDLE;
            default:  bus_state_next = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_state <= BUS_IDLE;
        end else begin
            bus_state <= bus_state_next;
        end
    end

    assign fc_bus   = (bus_state == BUS_ACK) ? 1'b1 : 1'bz;
    assign data_bus = rd_ack ? rd_data : 32'bz;

    always_comb begin
        status_val = '0;
        status_val[ST_FULL]  = fifo_full;
        status_val[ST_EMPTY] = fifo_empty;
        status_val[ST_BUSY]  = busy;
        status_val[ST_OVF]   = overflow;
        status_val[ST_COUNT +: FIFO_AW+1] = fifo_count;

        ctrl_val = '0;
        ctrl_val[CT_ENABLE] = enable;
        ctrl_val[CT_IRQ_EN] = irq_en;

        case (offset)
            REG_STATUS: reg_val = status_val;
            REG_CTRL:   reg_val = ctrl_val;
            default:    reg_val = '0;
        endcase

        // Disabled byte lanes read back as zero.
        rd_data = '0;
        for (int k = 0; k < 4; k++) begin
            rd_data[8*k +: 8] = data_mask_bus[k] ? reg_val[8*k +: 8] : 8'h00;
        end
    end

    assign data_push = wr_ack && (offset == REG_DATA) && data_mask_bus[0];
    assign ctrl_wr   = wr_ack && (offset == REG_CTRL) && data_mask_bus[0];
    assign flush     = ctrl_wr && data_bus[CT_FLUSH];
    assign clr_ovf   = ctrl_wr && data_bus[CT_CLR_OVF];

    always_ff @(posedge clk) begin
        if (rst) begin
            enable   <= 1'b1;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable <= data_bus[CT_ENABLE];
                irq_en <= data_bus[CT_IRQ_EN];
            end
            if (clr_ovf) begin
                overflow <= 1'b0;
            end else if (data_push && fifo_full && !ser_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    bus_uart_tx_fifo #(
        .AW (FIFO_AW),
        .DW (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_push),
        .wdata (data_bus[7:0]),
        .pop   (ser_pop),
        .flush (flush),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign start_ok  = enable && !fifo_empty;
    assign baud_done = (baud_cnt == DIV_LAST);
    assign busy      = (ser_state != SER_IDLE);

    always_comb begin
        ser_state_next = ser_state;
        ser_pop        = 1'b0;
        case (ser_state)
            SER_IDLE: begin
                if (start_ok) begin
                    ser_state_next = SER_START;
                    ser_pop        = 1'b1;
                end
            end
            SER_START: if (baud_done) ser_state_next = SER_DATA;
            SER_DATA:  if (baud_done && (bit_idx == 3'd7)) ser_state_next = SER_STOP;
            SER_STOP: begin
                if (baud_done) begin
                    // Chain straight into the next start bit when more data waits.
                    if (start_ok) begin
                        ser_state_next = SER_START;
                        ser_pop        = 1'b1;
                    end else begin
                        ser_state_next = SER_IDLE;
                    end
                end
            end
            default: ser_state_next = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ser_state <= SER_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'hFF;
        end else begin
            ser_state <= ser_state_next;
            // Every state (and every data bit) is entered on baud_done or from IDLE.
            if ((ser_state == SER_IDLE) || baud_done) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CW'(1);
            end
            if (ser_pop) begin
                shreg   <= fifo_rdata;
                bit_idx <= 3'd0;
            end else if ((ser_state == SER_DATA) && baud_done) begin
                shreg   <= {1'b1, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        case (ser_state)
            SER_START: tx = 1'b0;
            SER_DATA:  tx = shreg[0];
            default:   tx = 1'b1;
        endcase
    end

    assign irq = irq_en && fifo_empty && !busy;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed bench for bus_uart_tx at DIV=10: register vector table, bus corner
// sequences and a line monitor that decodes every frame against exp_q.
module tb_bus_uart_tx;

    localparam logic [31:0] BASE = 32'h7000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'h0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [3:0]  mask = 4'h0;
    logic [31:0] drv_data = 32'h0;
    logic        drv_en = 1'b0;
    wire  [31:0] data_bus;
    wire         fc_bus;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames_done = 0;
    logic [7:0] exp_q[$];
    int start_log[$];
    int end_log[$];

    assign data_bus = drv_en ? drv_data : 32'bz;

    bus_uart_tx #(
        .BASE_ADDR (BASE),
        .CLK_FREQ  (1_000_000),
        .BAUD      (100_000),
        .FIFO_AW   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .addr_bus      (addr),
        .data_bus      (data_bus),
        .rd_bus        (rd),
        .wr_bus        (wr),
        .data_mask_bus (mask),
        .fc_bus        (fc_bus),
        .tx            (tx),
        .irq           (irq)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by time %0t expected finish", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- line monitor / scoreboard ----------------
    logic       mon_active = 1'b0;
    logic       mon_valid = 1'b0;
    logic       mon_bad = 1'b0;
    int         mon_pos = 0;
    logic [7:0] mon_exp = 8'h0;
    logic [7:0] mon_got = 8'h0;
    logic       exp_bit;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx !== 1'b1) begin
                mon_active = 1'b1;
                mon_pos    = 0;
                mon_bad    = 1'b0;
                mon_got    = 8'h0;
                start_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    mon_valid = 1'b0;
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected_frame: got start bit at cycle %0d expected idle line", cyc);
                end else begin
                    mon_valid = 1'b1;
                    mon_exp   = exp_q.pop_front();
                end
            end
        end else begin
            mon_pos++;
            if (mon_pos < 10) exp_bit = 1'b0;
            else if (mon_pos >= 90) exp_bit = 1'b1;
            else exp_bit = mon_exp[(mon_pos / 10) - 1];
            if (tx !== exp_bit) mon_bad = 1'b1;
            if ((mon_pos >= 10) && (mon_pos < 90) && ((mon_pos % 10) == 5))
                mon_got[(mon_pos / 10) - 1] = tx;
            if (mon_pos == 99) begin
                mon_active = 1'b0;
                end_log.push_back(cyc);
                frames_done++;
                if (mon_valid) begin
                    checks++;
                    if (mon_bad) begin
                        errors++;
                        $display("FAIL tx_frame: got byte 0x%02h (bit shape/timing off) expected 0x%02h",
                                 mon_got, mon_exp);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bus_access(input logic is_wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m, output logic [31:0] rdata, output int ack_cyc);
        logic seen;
        @(posedge clk); #1;
        addr = a; rd = !is_wr; wr = is_wr; mask = m; drv_data = d; drv_en = is_wr;
        seen = 1'b0; rdata = 32'h0; ack_cyc = -1;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk);
            if (fc_bus === 1'b1) begin
                seen = 1'b1;
                rdata = data_bus;
                ack_cyc = cyc;
            end
        end
        check("bus_ack_seen", {31'h0, seen}, 32'h1);
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0; drv_en = 1'b0;
        @(negedge clk);
        check("bus_fc_single", {31'h0, fc_bus === 1'b1}, 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [31:0] d, output int ack_cyc);
        logic [31:0] dummy;
        bus_access(1'b1, BASE | {28'h0, off}, d, 4'hF, dummy, ack_cyc);
    endtask

    task automatic bus_read(input logic [3:0] off, output logic [31:0] v);
        int a;
        bus_access(1'b0, BASE | {28'h0, off}, 32'h0, 4'hF, v, a);
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && frames_done < target; i++) @(negedge clk);
        check("frames_done", frames_done, target);
    endtask

    task automatic probe_no_ack(input logic [31:0] a);
        int pulses;
        @(posedge clk); #1;
        addr = a; rd = 1'b1; mask = 4'hF;
        pulses = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (fc_bus === 1'b1) pulses++;
        end
        check("out_of_window_ack", pulses, 0);
        @(posedge clk); #1;
        rd = 1'b0;
    endtask

    task automatic wait_cycle(input int target);
        for (int g = 0; g < 1000 && cyc < target; g++) @(negedge clk);
        check("cycle_reached", {31'h0, cyc == target}, 32'h1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        is_wr;
        logic [3:0]  off;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0] v;
        int ack;
        int ack2;
        int f0;
        int n_starts;
        int pulses;

        vecs[0]  = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h0000_0002, 1'b0};
        vecs[1]  = '{1'b0, 4'h8, 32'h0,        4'hF, 32'h0000_0001, 1'b0};
        vecs[2]  = '{1'b0, 4'h0, 32'h0,        4'hF, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 4'hC, 32'h0,        4'hF, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b1, 4'h8, 32'h8,        4'hF, 32'h0,         1'b1};
        vecs[5]  = '{1'b0, 4'h8, 32'h0,        4'hF, 32'h0000_0008, 1'b1};
        vecs[6]  = '{1'b1, 4'h8, 32'h1,        4'h0, 32'h0,         1'b1};
        vecs[7]  = '{1'b0, 4'h8, 32'h0,        4'hF, 32'h0000_0008, 1'b1};
        vecs[8]  = '{1'b0, 4'h8, 32'h0,        4'hE, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 4'h0, 32'h77,       4'hE, 32'h0,         1'b1};
        vecs[10] = '{1'b0, 4'h4, 32'h0,        4'hF, 32'h0000_0002, 1'b1};
        vecs[11] = '{1'b1, 4'hC, 32'hFFFF_FFFF, 4'hF, 32'h0,        1'b1};
        vecs[12] = '{1'b0, 4'h8, 32'h0,        4'hF, 32'h0000_0008, 1'b1};
        vecs[13] = '{1'b1, 4'h8, 32'h1,        4'hF, 32'h0,         1'b0};
        vecs[14] = '{1'b0, 4'h8, 32'h0,        4'hF, 32'h0000_0001, 1'b0};
        vecs[15] = '{1'b0, 4'h4, 32'h0,        4'h2, 32'h0000_0000, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_during", {31'h0, tx}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx", {31'h0, tx}, 32'h1);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_fc", {31'h0, fc_bus === 1'b1}, 32'h0);

        // Register map vectors
        for (int i = 0; i < 16; i++) begin
            bus_access(vecs[i].is_wr, BASE | {28'h0, vecs[i].off}, vecs[i].wdata, vecs[i].mask, v, ack);
            if (!vecs[i].is_wr) check($sformatf("vec%0d_rdata", i), v, vecs[i].exp);
            @(negedge clk);
            check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
        end

        // Addresses just outside the window are ignored
        probe_no_ack(BASE + 32'h10);
        probe_no_ack(BASE - 32'h4);

        // Read held 5 cycles: one acknowledge, STATUS value on the bus
        @(posedge clk); #1;
        addr = BASE | 32'h4; rd = 1'b1; mask = 4'hF;
        pulses = 0; v = 32'hDEAD_BEEF;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (fc_bus === 1'b1) begin
                pulses++;
                v = data_bus;
            end
        end
        check("held_read_pulses", pulses, 1);
        check("held_read_data", v, 32'h0000_0002);
        @(posedge clk); #1;
        rd = 1'b0;
        @(negedge clk);
        check("held_read_fc_after", {31'h0, fc_bus === 1'b1}, 32'h0);

        // Single frame 0x55 and first-bit latency
        start_log.delete(); end_log.delete(); f0 = frames_done;
        exp_q.push_back(8'h55);
        bus_write(4'h0, 32'h55, ack);
        bus_read(4'h4, v);
        check("t1_status_busy", v, 32'h0000_0006);
        wait_frames(f0 + 1, 300);
        check("t1_nstarts", start_log.size(), 1);
        if (start_log.size() >= 1 && end_log.size() >= 1) begin
            check("t1_start_latency", start_log[0] - ack, 2);
            check("t1_frame_len", end_log[0] - start_log[0], 99);
        end
        bus_read(4'h4, v);
        check("t1_status_idle", v, 32'h0000_0002);

        // Fill with enable=0, overflow on 17th push, then clear + enable
        bus_write(4'h8, 32'h0, ack);
        f0 = frames_done;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back(8'(8'h10 + i));
            bus_write(4'h0, 32'h10 + i, ack);
        end
        bus_read(4'h4, v);
        check("t3_status_full", v, 32'h0000_1009);
        bus_write(4'h8, 32'h5, ack);
        bus_read(4'h4, v);
        check("t3_status_draining", v, 32'h0000_0F04);
        wait_frames(f0 + 16, 2000);
        bus_read(4'h4, v);
        check("t3_status_done", v, 32'h0000_0002);
        check("t3_exp_q_empty", exp_q.size(), 0);

        // Back-to-back frames
        start_log.delete(); end_log.delete(); f0 = frames_done;
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'h0F);
        bus_write(4'h0, 32'hA0, ack);
        bus_write(4'h0, 32'h0F, ack);
        wait_frames(f0 + 2, 400);
        if (start_log.size() >= 2 && end_log.size() >= 1) begin
            check("t4_gap", start_log[1] - end_log[0], 1);
            check("t4_period", start_log[1] - start_log[0], 100);
        end else begin
            check("t4_nstarts", start_log.size(), 2);
        end

        // Flush mid-frame: only the in-flight frame goes out
        start_log.delete(); end_log.delete(); f0 = frames_done;
        exp_q.push_back(8'h11);
        bus_write(4'h0, 32'h11, ack);
        bus_write(4'h0, 32'h22, ack);
        bus_write(4'h0, 32'h33, ack);
        bus_write(4'h8, 32'h3, ack);
        bus_read(4'h4, v);
        check("t5_status_flushed", v, 32'h0000_0006);
        wait_frames(f0 + 1, 300);
        repeat (150) @(negedge clk);
        check("t5_nstarts", start_log.size(), 1);
        bus_read(4'h4, v);
        check("t5_status_idle", v, 32'h0000_0002);

        // irq timing around one frame
        bus_write(4'h8, 32'h9, ack);
        @(negedge clk);
        check("t6_irq_idle", {31'h0, irq}, 32'h1);
        exp_q.push_back(8'h5A);
        bus_write(4'h0, 32'h5A, ack);
        @(negedge clk);
        check("t6_irq_busy", {31'h0, irq}, 32'h0);
        wait_cycle(ack + 101);
        check("t6_irq_last_stop", {31'h0, irq}, 32'h0);
        check("t6_tx_last_stop", {31'h0, tx}, 32'h1);
        @(negedge clk);
        check("t6_irq_back", {31'h0, irq}, 32'h1);

        // Reset in the middle of a frame, during a low data bit
        exp_q.push_back(8'h3C);
        bus_write(4'h0, 32'h3C, ack2);
        wait_cycle(ack2 + 2 + 24);
        check("t6_tx_low_before_rst", {31'h0, tx}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_tx", {31'h0, tx}, 32'h1);
        check("t6_rst_irq", {31'h0, irq}, 32'h0);
        check("t6_rst_fc", {31'h0, fc_bus === 1'b1}, 32'h0);
        n_starts = start_log.size();
        bus_read(4'h8, v);
        check("t6_rst_ctrl", v, 32'h0000_0001);
        bus_read(4'h4, v);
        check("t6_rst_status", v, 32'h0000_0002);
        repeat (150) @(negedge clk);
        check("t6_no_frame_after_rst", start_log.size(), n_starts);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
